// File: rtl/adc_spi_master.sv
// -----------------------------------------------------------------------------
// adc_spi_master
//
// 3-wire SPI master for single-register ADC configuration accesses.
// Each access is one 24-bit frame, sent MSB first:
//   {R/W (1 = read), 2'b00, 5'b00000, addr[7:0], data[7:0]}
// On a read, the master releases ADC_sdio for the last 8 bit periods and
// captures the ADC's reply byte.
//
// Frame timing (all in Clock cycles):
//   SETUP : SS_SETUP cycles, ss_n low, sclk low
//   SHIFT : 24 bit periods of 2*CLK_DIV cycles (sclk low half, then high half)
//   HOLD  : SS_HOLD cycles, ss_n low, sclk low
//
// Optional feature (compile macro ADC_SPI_AUTO_TRANSFER_EN):
//   every write frame is followed, after SS_HOLD cycles with ss_n high, by an
//   automatic write of 0x01 to register 0xFF (transfer/update strobe).
//   C_busy stays high across both frames and the gap. Reads are unaffected.
//
// Handshake: a command is accepted on a rising Clock edge where
// C_enable_cmd = 1 and C_busy = 0. Strobes while C_busy = 1 are dropped.
//
// Ports:
//   Clock, Reset_N         clock (rising edge) / async active-low reset
//   C_enable_cmd           single-cycle command strobe
//   C_write_read           1 = write, 0 = read
//   C_addr_frame[7:0]      register address
//   C_write_data_frame[15:0] write data; only [7:0] is sent
//   C_busy                 access in progress
//   C_read_data_frame[15:0] last read byte, zero-extended
//   ADC_sclk               SPI clock, idles low
//   ADC_ss_n               chip select, idles high
//   ADC_sdio_o/_oe/_i      bidirectional data pin (to/from the pad buffer)
// -----------------------------------------------------------------------------
module adc_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2
) (
    input  logic        Clock,
    input  logic        Reset_N,
    input  logic        C_enable_cmd,
    input  logic        C_write_read,
    input  logic [7:0]  C_addr_frame,
    input  logic [15:0] C_write_data_frame,
    output logic        C_busy,
    output logic [15:0] C_read_data_frame,
    output logic        ADC_sclk,
    output logic        ADC_ss_n,
    output logic        ADC_sdio_o,
    output logic        ADC_sdio_oe,
    input  logic        ADC_sdio_i
);

    localparam int PER  = 2 * CLK_DIV;
    localparam int CMAX = (PER > SS_SETUP) ? ((PER > SS_HOLD) ? PER : SS_HOLD)
                                           : ((SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PER_LAST   = CW'(PER - 1);
    localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(CLK_DIV - 1);   // last low cycle; sclk rises at its end
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(SS_HOLD - 1);
    localparam logic [4:0]    BIT_LAST   = 5'd23;
    localparam logic [4:0]    BIT_DATA0  = 5'd16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4   // ss_n high between a write and its auto-transfer frame
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;      // cycle counter within SETUP/HOLD/GAP or bit period
    logic [4:0]      bit_q, bit_d;      // bit period index 0..23
    logic [23:0]     sh_q, sh_d;        // outgoing frame, bit 23 on the wire
    logic [7:0]      rx_q, rx_d;        // incoming read byte
    logic            rd_q, rd_d;        // current frame is a read
    logic [15:0]     rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            sclk_q, sclk_d;
    logic            ss_n_q, ss_n_d;
    logic            sdo_q, sdo_d;
    logic            oe_q, oe_d;
`ifdef ADC_SPI_AUTO_TRANSFER_EN
    logic            auto_q, auto_d;    // current frame is the automatic 0xFF strobe
`endif

    // Frame-load request shared by command acceptance and the auto-transfer.
    logic            load;
    logic            load_rd;
    logic [7:0]      load_addr;
    logic [7:0]      load_data;
    logic            frame_done;

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^C_write_data_frame[15:8];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
`ifdef ADC_SPI_AUTO_TRANSFER_EN
        auto_d     = auto_q;
`endif
        load       = 1'b0;
        load_rd    = 1'b0;
        load_addr  = 8'h00;
        load_data  = 8'h00;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                // C_busy is low in IDLE, so a strobe here is always accepted.
                if (C_enable_cmd) begin
                    load      = 1'b1;
                    load_rd   = ~C_write_read;
                    load_addr = C_addr_frame;
                    load_data = C_write_data_frame[7:0];
`ifdef ADC_SPI_AUTO_TRANSFER_EN
                    auto_d    = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                // Capture on the edge where sclk goes high.
                if (cnt_q == SAMPLE_CNT && rd_q && bit_q >= BIT_DATA0) begin
                    rx_d = {rx_q[6:0], ADC_sdio_i};
                end
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (SS_HOLD > 0) begin
                            state_d = HOLD;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                        sh_d  = {sh_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    frame_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef ADC_SPI_AUTO_TRANSFER_EN
            GAP: begin
                if (cnt_q == HOLD_LAST) begin
                    load      = 1'b1;
                    load_rd   = 1'b0;
                    load_addr = 8'hFF;
                    load_data = 8'h01;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_done) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rd_q) begin
                rdata_d = {8'h00, rx_d};
            end
`ifdef ADC_SPI_AUTO_TRANSFER_EN
            if (!rd_q && !auto_q) begin
                auto_d = 1'b1;
                if (SS_HOLD > 0) begin
                    state_d = GAP;
                end else begin
                    load      = 1'b1;
                    load_rd   = 1'b0;
                    load_addr = 8'hFF;
                    load_data = 8'h01;
                end
            end
`endif
        end

        if (load) begin
            rd_d    = load_rd;
            sh_d    = {load_rd, 2'b00, 5'b00000, load_addr, load_data};
            rx_d    = '0;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = (SS_SETUP > 0) ? SETUP : SHIFT;
        end

        // Pin values are registered from the next state so they are glitch-free.
        busy_d = (state_d != IDLE);
        ss_n_d = (state_d == IDLE) || (state_d == GAP);
        sclk_d = (state_d == SHIFT) && (cnt_d >= HALF);
        oe_d   = (state_d inside {SETUP, SHIFT, HOLD}) &&
                 !(rd_d && ((state_d == HOLD) || (state_d == SHIFT && bit_d >= BIT_DATA0)));
        sdo_d  = oe_d & sh_d[23];
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
`ifdef ADC_SPI_AUTO_TRANSFER_EN
            auto_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
            sdo_q   <= sdo_d;
            oe_q    <= oe_d;
`ifdef ADC_SPI_AUTO_TRANSFER_EN
            auto_q  <= auto_d;
`endif
        end
    end

    assign C_busy            = busy_q;
    assign C_read_data_frame = rdata_q;
    assign ADC_sclk          = sclk_q;
    assign ADC_ss_n          = ss_n_q;
    assign ADC_sdio_o        = sdo_q;
    assign ADC_sdio_oe       = oe_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_master
//
// Directed bench for adc_spi_master with CLK_DIV=2, SS_SETUP=2, SS_HOLD=2.
// A frame then keeps C_busy high for 2 + 96 + 2 = 100 cycles; with
// ADC_SPI_AUTO_TRANSFER_EN a write takes 100 + 2 + 100 = 202 cycles.
// Pin monitors record sdio/oe at every sclk rise; a small ADC model drives
// the reply byte after sclk falls 15..22 of each frame.
// -----------------------------------------------------------------------------
module tb_adc_spi_master;

  localparam int CLK_DIV  = 2;
  localparam int SS_SETUP = 2;
  localparam int SS_HOLD  = 2;

`ifdef ADC_SPI_AUTO_TRANSFER_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        Clock;
  logic        Reset_N;
  logic        C_enable_cmd;
  logic        C_write_read;
  logic [7:0]  C_addr_frame;
  logic [15:0] C_write_data_frame;
  logic        C_busy;
  logic [15:0] C_read_data_frame;
  logic        ADC_sclk;
  logic        ADC_ss_n;
  logic        ADC_sdio_o;
  logic        ADC_sdio_oe;
  logic        ADC_sdio_i = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  adc_spi_master #(
    .CLK_DIV  (CLK_DIV),
    .SS_SETUP (SS_SETUP),
    .SS_HOLD  (SS_HOLD)
  ) dut (
    .Clock              (Clock),
    .Reset_N            (Reset_N),
    .C_enable_cmd       (C_enable_cmd),
    .C_write_read       (C_write_read),
    .C_addr_frame       (C_addr_frame),
    .C_write_data_frame (C_write_data_frame),
    .C_busy             (C_busy),
    .C_read_data_frame  (C_read_data_frame),
    .ADC_sclk           (ADC_sclk),
    .ADC_ss_n           (ADC_ss_n),
    .ADC_sdio_o         (ADC_sdio_o),
    .ADC_sdio_oe        (ADC_sdio_oe),
    .ADC_sdio_i         (ADC_sdio_i)
  );

  // ---------------- pin monitors and ADC model ----------------
  int          rise_cnt    = 0;
  int          sclk_viol   = 0;
  int          ss_fall_cnt = 0;
  int          last_gap    = 0;
  int          frame_fall  = 0;
  int          seen_fall   = 0;
  time         ss_rise_t   = 0;
  logic [47:0] mon_tx      = '0;
  logic [47:0] mon_oe      = '0;
  logic        oe_f14      = 1'bx;
  logic        oe_f15      = 1'bx;
  logic [7:0]  slave_byte;

  always @(posedge ADC_sclk) begin
    rise_cnt++;
    mon_tx = {mon_tx[46:0], ADC_sdio_o};
    mon_oe = {mon_oe[46:0], ADC_sdio_oe};
    if (ADC_ss_n !== 1'b0) sclk_viol++;
  end

  always @(ADC_ss_n) begin
    if (ADC_ss_n === 1'b1) begin
      ss_rise_t = $time;
    end else if (ADC_ss_n === 1'b0) begin
      ss_fall_cnt++;
      last_gap = int'(($time - ss_rise_t) / 10);
    end
  end

  // After sclk fall k the ADC puts reply bit (7-(k-15)) on the line, so the
  // master sees it at rising edges 16..23.
  always @(negedge ADC_sclk) begin
    int idx;
    if (seen_fall != ss_fall_cnt) begin
      seen_fall  = ss_fall_cnt;
      frame_fall = 0;
    end
    idx = frame_fall;
    frame_fall++;
    if (idx >= 15 && idx <= 22) ADC_sdio_i = slave_byte[3'(22 - idx)];
    #1;
    if (idx == 14) oe_f14 = ADC_sdio_oe;
    if (idx == 15) oe_f15 = ADC_sdio_oe;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          busy_cycles;
  int          rise0;
  int          ssf0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    exp_q.push_back(exp);
    assert (obs === exp_q.pop_front())
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    rise0 = rise_cnt;
    ssf0  = ss_fall_cnt;
  endtask

  // ---------------- driver ----------------
  // Issues one command, then counts the sampled cycles with C_busy high.
  // repulse_at > 0 fires a second (read 0x33) strobe that many cycles in.
  task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                         input int repulse_at, input bit no_wait);
    int n;
    if (!no_wait) @(negedge Clock);
    C_write_read       = wr;
    C_addr_frame       = addr;
    C_write_data_frame = wdata;
    C_enable_cmd       = 1'b1;
    @(negedge Clock);
    C_enable_cmd = 1'b0;
    n = 0;
    while (C_busy === 1'b1 && n < 1000) begin
      n++;
      if (repulse_at != 0 && n == repulse_at) begin
        C_write_read       = 1'b0;
        C_addr_frame       = 8'h33;
        C_write_data_frame = 16'h00EE;
        C_enable_cmd       = 1'b1;
      end else begin
        C_enable_cmd = 1'b0;
      end
      @(negedge Clock);
    end
    C_enable_cmd = 1'b0;
    busy_cycles  = n;
    check("busy_done", C_busy, 48'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    Reset_N            = 1'b0;
    C_enable_cmd       = 1'b0;
    C_write_read       = 1'b0;
    C_addr_frame       = 8'h00;
    C_write_data_frame = 16'h0000;
    slave_byte         = 8'h00;
    repeat (3) @(negedge Clock);

    // Reset values
    check("rst_busy",  C_busy,            48'h0);
    check("rst_rdata", C_read_data_frame, 48'h0);
    check("rst_sclk",  ADC_sclk,          48'h0);
    check("rst_ss_n",  ADC_ss_n,          48'h1);
    check("rst_sdo",   ADC_sdio_o,        48'h0);
    check("rst_oe",    ADC_sdio_oe,       48'h0);
    Reset_N = 1'b1;
    @(negedge Clock);

    // Read addr 0x01, ADC answers 0xA5
    slave_byte = 8'hA5;
    snap();
    run_cmd(1'b0, 8'h01, 16'h0000, 0, 1'b0);
    check("rd_hdr",    mon_tx[23:8],      48'h8001);
    check("rd_rises",  rise_cnt - rise0,  48'd24);
    check("rd_oe_map", mon_oe[23:0],      48'hFFFF00);
    check("rd_oe_b15", oe_f14,            48'h1);
    check("rd_oe_b16", oe_f15,            48'h0);
    check("rd_busy",   busy_cycles,       48'd100);
    check("rd_data",   C_read_data_frame, 48'h00A5);

    // Write addr 0x14 data 0x0005
    snap();
    run_cmd(1'b1, 8'h14, 16'h0005, 0, 1'b0);
    check("wr_tx",    AUTO ? mon_tx : {24'h0, mon_tx[23:0]},
                      AUTO ? 48'h001405_00FF01 : 48'h001405);
    check("wr_oe",    AUTO ? mon_oe : {24'h0, mon_oe[23:0]},
                      AUTO ? 48'hFFFFFF_FFFFFF : 48'hFFFFFF);
    check("wr_rises", rise_cnt - rise0,  AUTO ? 48'd48 : 48'd24);
    check("wr_busy",  busy_cycles,       AUTO ? 48'd202 : 48'd100);
    check("wr_rdata", C_read_data_frame, 48'h00A5);

    // Strobe 10 cycles into an access is dropped
    snap();
    run_cmd(1'b1, 8'h22, 16'h005A, 10, 1'b0);
    check("ign_rises", rise_cnt - rise0,     AUTO ? 48'd48 : 48'd24);
    check("ign_ss",    ss_fall_cnt - ssf0,   AUTO ? 48'd2 : 48'd1);
    check("ign_tx",    AUTO ? mon_tx : {24'h0, mon_tx[23:0]},
                       AUTO ? 48'h00225A_00FF01 : 48'h00225A);
    check("ign_busy",  busy_cycles,          AUTO ? 48'd202 : 48'd100);
    check("ign_rdata", C_read_data_frame,    48'h00A5);

    // Back-to-back reads: second strobe in the first cycle C_busy is low
    slave_byte = 8'h3C;
    run_cmd(1'b0, 8'h02, 16'h0000, 0, 1'b0);
    check("b2b_data1", C_read_data_frame, 48'h003C);
    slave_byte = 8'hC3;
    snap();
    run_cmd(1'b0, 8'h03, 16'h0000, 0, 1'b1);
    check("b2b_gap",   last_gap,          48'd1);
    check("b2b_hdr",   mon_tx[23:8],      48'h8003);
    check("b2b_data2", C_read_data_frame, 48'h00C3);
    check("b2b_busy",  busy_cycles,       48'd100);

    // Write addr 0x08 data 0x03 (auto-transfer pair when enabled).
    // Without the feature the gap measured is the 2-cycle idle before it.
    snap();
    run_cmd(1'b1, 8'h08, 16'h0003, 0, 1'b0);
    check("at_tx",   AUTO ? mon_tx : {24'h0, mon_tx[23:0]},
                     AUTO ? 48'h000803_00FF01 : 48'h000803);
    check("at_busy", busy_cycles,        AUTO ? 48'd202 : 48'd100);
    check("at_ss",   ss_fall_cnt - ssf0, AUTO ? 48'd2 : 48'd1);
    check("at_gap",  last_gap,           48'd2);

    // Reset after 10 sclk rises of a read
    slave_byte = 8'h5A;
    snap();
    @(negedge Clock);
    C_write_read = 1'b0;
    C_addr_frame = 8'h10;
    C_enable_cmd = 1'b1;
    @(negedge Clock);
    C_enable_cmd = 1'b0;
    n = 0;
    while ((rise_cnt - rise0) < 10 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    check("mid_rises", rise_cnt - rise0, 48'd10);
    #2 Reset_N = 1'b0;
    #1;
    check("mid_ss_n",  ADC_ss_n,          48'h1);
    check("mid_sclk",  ADC_sclk,          48'h0);
    check("mid_oe",    ADC_sdio_oe,       48'h0);
    check("mid_busy",  C_busy,            48'h0);
    check("mid_rdata", C_read_data_frame, 48'h0);
    @(negedge Clock);
    @(negedge Clock);
    Reset_N = 1'b1;
    @(negedge Clock);

    // Normal write after reset release
    snap();
    run_cmd(1'b1, 8'h05, 16'h0077, 0, 1'b0);
    check("post_tx",    AUTO ? mon_tx : {24'h0, mon_tx[23:0]},
                        AUTO ? 48'h000577_00FF01 : 48'h000577);
    check("post_busy",  busy_cycles,       AUTO ? 48'd202 : 48'd100);
    check("post_rdata", C_read_data_frame, 48'h0);

    // No sclk rise ever seen with ss_n high
    check("sclk_ss", sclk_viol, 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
